// File: rtl/memwb_stage.sv
// MEM/WB pipeline stage with a one-deep skid buffer.
// Beats are held in a main register, which drives the outputs, and a skid
// register that absorbs one extra beat so in_ready can be registered.
//   clk, rst      : clock and synchronous active-high reset
//   flush         : discard all held beats (data fields kept, state -> EMPTY)
//   in_*          : upstream valid/ready beat (control bits, data, rd)
//   out_*         : WB beat; out_wbdata selects memdata or alures
//   stall_cnt     : saturating count of cycles with out_valid & !out_ready
module memwb_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memtoreg,
  input  logic              in_regwrite,
  input  logic              in_pcsrc,
  input  logic              in_jump,
  input  logic [DATA_W-1:0] in_memdata,
  input  logic [DATA_W-1:0] in_alures,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_memtoreg,
  output logic              out_regwrite,
  output logic              out_pcsrc,
  output logic              out_jump,
  output logic [DATA_W-1:0] out_memdata,
  output logic [DATA_W-1:0] out_alures,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_wbdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic              memtoreg;
    logic              regwrite;
    logic              pcsrc;
    logic              jump;
    logic [DATA_W-1:0] memdata;
    logic [DATA_W-1:0] alures;
    logic [RD_W-1:0]   rd;
  } beat_t;

  state_t state, state_nx;
  beat_t  main_q, skid_q, in_beat;
  logic   accept, pop;
  logic   load_main_in, load_skid_in, load_main_skid;

  assign in_beat = '{memtoreg: in_memtoreg, regwrite: in_regwrite,
                     pcsrc: in_pcsrc, jump: in_jump, memdata: in_memdata,
                     alures: in_alures, rd: in_rd};

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nx     = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid_in = 1'b1;
          state_nx     = TWO;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          load_main_skid = 1'b1;
          state_nx       = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // Flush wins over any transfer; register loads are suppressed below.
    if (flush) state_nx = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != TWO);
      if (!flush) begin
        if (load_main_in)   main_q <= in_beat;
        if (load_main_skid) main_q <= skid_q;
        if (load_skid_in)   skid_q <= in_beat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_memtoreg = main_q.memtoreg;
  assign out_regwrite = main_q.regwrite & out_valid & (main_q.rd != '0);
  assign out_pcsrc    = main_q.pcsrc & out_valid;
  assign out_jump     = main_q.jump & out_valid;
  assign out_memdata  = main_q.memdata;
  assign out_alures   = main_q.alures;
  assign out_rd       = main_q.rd;
  assign out_wbdata   = out_memtoreg ? out_memdata : out_alures;

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_memtoreg = 1'b0, in_regwrite = 1'b0, in_pcsrc = 1'b0, in_jump = 1'b0;
  logic [31:0] in_memdata = '0, in_alures = '0;
  logic [4:0]  in_rd = '0;

  logic        in_ready, out_valid, out_memtoreg, out_regwrite, out_pcsrc, out_jump;
  logic [31:0] out_memdata, out_alures, out_wbdata;
  logic [4:0]  out_rd;
  logic [15:0] stall_cnt;

  logic        in_ready4, out_valid4, out_memtoreg4, out_regwrite4, out_pcsrc4, out_jump4;
  logic [31:0] out_memdata4, out_alures4, out_wbdata4;
  logic [4:0]  out_rd4;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  memwb_stage #(.DATA_W(32), .RD_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_pcsrc(in_pcsrc),
    .in_jump(in_jump), .in_memdata(in_memdata), .in_alures(in_alures), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_memtoreg(out_memtoreg),
    .out_regwrite(out_regwrite), .out_pcsrc(out_pcsrc), .out_jump(out_jump),
    .out_memdata(out_memdata), .out_alures(out_alures), .out_rd(out_rd),
    .out_wbdata(out_wbdata), .stall_cnt(stall_cnt)
  );

  memwb_stage #(.DATA_W(32), .RD_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_pcsrc(in_pcsrc),
    .in_jump(in_jump), .in_memdata(in_memdata), .in_alures(in_alures), .in_rd(in_rd),
    .out_valid(out_valid4), .out_ready(out_ready), .out_memtoreg(out_memtoreg4),
    .out_regwrite(out_regwrite4), .out_pcsrc(out_pcsrc4), .out_jump(out_jump4),
    .out_memdata(out_memdata4), .out_alures(out_alures4), .out_rd(out_rd4),
    .out_wbdata(out_wbdata4), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic        mtr, rw, pc, jp;
    logic [31:0] md, ar;
    logic [4:0]  rd;
  } beat_t;

  beat_t q[$];
  int    checks = 0, errors = 0;
  bit    chk_en = 1'b0;
  int    stall_model = 0, stall4_model = 0, accepted = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check occupancy
  // and counters against the model and record what the coming edge accepts.
  task automatic cycle(input logic v, input logic rdy, input logic fl, input logic rs,
                       input logic mtr, input logic rw, input logic pc, input logic jp,
                       input logic [31:0] md, input logic [31:0] ar, input logic [4:0] rd);
    beat_t b;
    @(negedge clk);
    in_valid = v; out_ready = rdy; flush = fl; rst = rs;
    in_memtoreg = mtr; in_regwrite = rw; in_pcsrc = pc; in_jump = jp;
    in_memdata = md; in_alures = ar; in_rd = rd;
    #1;
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("stall_cnt", 64'(stall_cnt), 64'(stall_model));
      chk("stall_cnt4", 64'(stall_cnt4), 64'(stall4_model));
      chk("dut4_outputs", 64'({in_ready4, out_valid4, out_memtoreg4, out_regwrite4,
                               out_pcsrc4, out_jump4, out_rd4}),
                          64'({in_ready, out_valid, out_memtoreg, out_regwrite,
                               out_pcsrc, out_jump, out_rd}));
      chk("dut4_data", {out_wbdata4, out_alures4 ^ out_memdata4},
                       {out_wbdata, out_alures ^ out_memdata});
    end
    if (rs) begin
      stall_model = 0; stall4_model = 0;
    end else begin
      if (out_valid && !rdy) begin
        if (stall_model < 65535) stall_model++;
        if (stall4_model < 15) stall4_model++;
      end
    end
    if (rs || fl) begin
      q.delete();
    end else if (v && in_ready) begin
      b = '{mtr: mtr, rw: rw, pc: pc, jp: jp, md: md, ar: ar, rd: rd};
      q.push_back(b);
      accepted++;
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic send(input logic rdy, input logic [31:0] ar, input logic [4:0] rd);
    cycle(1'b1, rdy, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000, ar, rd);
  endtask

  // Monitor: on every pop, compare the presented beat with the oldest expected.
  always @(negedge clk) begin
    beat_t e;
    #2;
    if (chk_en && !rst && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_pop", 64'(out_valid), 64'(0));
      end else begin
        e = q.pop_front();
        chk("pop_rd", 64'(out_rd), 64'(e.rd));
        chk("pop_memdata", 64'(out_memdata), 64'(e.md));
        chk("pop_alures", 64'(out_alures), 64'(e.ar));
        chk("pop_wbdata", 64'(out_wbdata), 64'(e.mtr ? e.md : e.ar));
        chk("pop_ctrl", 64'({out_memtoreg, out_regwrite, out_pcsrc, out_jump}),
                        64'({e.mtr, e.rw && (e.rd != 0), e.pc, e.jp}));
      end
    end
  end

  initial begin
    int cyc;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk_en = 1'b1;
    idle(1'b0);
    chk("reset_data", {out_memdata, out_alures}, 64'(0));
    chk("reset_ctrl", 64'({out_memtoreg, out_regwrite, out_pcsrc, out_jump, out_rd}), 64'(0));

    // First beat appears the cycle after acceptance.
    send(1'b1, 32'h0000_00AA, 5'd3);
    idle(1'b1);
    chk("first_wbdata", 64'(out_wbdata), 64'h0000_00AA);
    chk("first_regwrite", 64'(out_regwrite), 64'(1));

    // Back-pressure: A and B fill the stage, a third offer is refused.
    send(1'b0, 32'h0000_000A, 5'd1);
    send(1'b0, 32'h0000_000B, 5'd2);
    send(1'b0, 32'h0000_000C, 5'd4);
    chk("two_in_ready", 64'(in_ready), 64'(0));
    chk("two_head", 64'(out_alures), 64'h0000_000A);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("after_A_in_ready", 64'(in_ready), 64'(1));
    chk("after_A_head", 64'(out_alures), 64'h0000_000B);
    idle(1'b1);

    // rd=0 suppresses regwrite; memtoreg selects memory data.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h5555_5555, 5'd0);
    idle(1'b0);
    chk("rd0_regwrite", 64'(out_regwrite), 64'(0));
    chk("mtr_wbdata", 64'(out_wbdata), 64'h1234_5678);
    idle(1'b1);

    // Flush in TWO with a beat offered: everything is dropped.
    send(1'b0, 32'h0000_0011, 5'd5);
    send(1'b0, 32'h0000_0022, 5'd6);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h0000_0033, 5'd7);
    idle(1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    send(1'b1, 32'h0000_0044, 5'd8);
    idle(1'b1);
    chk("post_flush_beat", 64'(out_alures), 64'h0000_0044);

    // Saturation of the narrow counter, then reset in TWO and clean restart.
    send(1'b0, 32'h0000_0055, 5'd9);
    send(1'b0, 32'h0000_0066, 5'd10);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("sat_stall4", 64'(stall_cnt4), 64'(15));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h77, 5'd11);
    idle(1'b1);
    chk("rst_stall4", 64'(stall_cnt4), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    send(1'b1, 32'h0000_0088, 5'd12);
    idle(1'b1);
    chk("post_rst_beat", 64'(out_alures), 64'h0000_0088);

    // Random traffic with rare flush/reset.
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 40000) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            $urandom_range(0, 499) == 0, $urandom_range(0, 1999) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, 5'($urandom_range(0, 31)));
      cyc++;
    end
    chk("random_progress", 64'(accepted >= 10000), 64'(1));
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drained", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memwb_stage.md
MEMWB_STAGE -- requirements
Module: memwb_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU-result and memory-data fields.
REQ-002 Parameter RD_W, default 5, width of the destination-register field.
REQ-003 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Port flush, input, 1, synchronous discard of all held beats.
REQ-007 Port in_valid, input, 1, upstream beat present.
REQ-008 Port in_ready, output, 1, stage can accept a beat this cycle; registered.
REQ-009 Port in_memtoreg / in_regwrite / in_pcsrc / in_jump, input, 1 each, MEM-stage control bits.
REQ-010 Port in_memdata / in_alures, input, DATA_W each, MEM-stage data.
REQ-011 Port in_rd, input, RD_W, destination register.
REQ-012 Port out_valid, output, 1, WB beat present.
REQ-013 Port out_ready, input, 1, WB consumer accepts the beat.
REQ-014 Port out_memtoreg / out_regwrite / out_pcsrc / out_jump, output, 1 each, WB control bits.
REQ-015 Port out_memdata / out_alures, output, DATA_W each; out_rd, output, RD_W.
REQ-016 Port out_wbdata, output, DATA_W, selected write-back value.
REQ-017 Port stall_cnt, output, CNT_W, saturating count of back-pressure cycles.

Function
REQ-018 The stage SHALL hold beats in a main register (drives outputs) and one skid register; states EMPTY, ONE, TWO.
REQ-019 accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, updated registered from next state.
REQ-021 EMPTY: accept loads main, next ONE; otherwise stay EMPTY.
REQ-022 ONE: accept & pop loads main with the new beat, stay ONE; accept & !pop loads skid, next TWO; pop & !accept next EMPTY; neither, hold.
REQ-023 TWO: pop copies skid to main, next ONE; no beat accepted in TWO.
REQ-024 out_valid SHALL be 1 exactly in ONE and TWO.
REQ-025 Beats SHALL leave in acceptance order; no beat lost or duplicated absent flush/rst.
REQ-026 Latency: a beat accepted in EMPTY appears at the outputs the next cycle.
REQ-027 out_regwrite SHALL equal stored regwrite & out_valid & (out_rd != 0).
REQ-028 out_pcsrc and out_jump SHALL be stored value & out_valid.
REQ-029 out_wbdata SHALL be out_memdata when out_memtoreg=1, else out_alures; combinational from main register.
REQ-030 Main and skid registers SHALL hold their contents when not loaded.
REQ-031 flush SHALL force next state EMPTY and in_ready=1 next cycle; beat offered with flush is discarded; flush outranks accept/pop; data fields are not cleared.
REQ-032 stall_cnt SHALL increment each cycle with out_valid & !out_ready, saturate at all-ones, and be unaffected by flush.

Reset
REQ-033 rst SHALL outrank flush and all transfers.
REQ-034 On rst: state EMPTY, in_ready=1, out_valid=0, all out_* control bits 0, out_memdata/out_alures/out_rd and skid contents 0, stall_cnt=0.
REQ-035 rst asserted in TWO SHALL drop both held beats; first beat after rst release is accepted normally.

Verification
REQ-036 rst then in_valid=1, alures=0x0000_00AA, rd=3, regwrite=1, out_ready=1 -> next cycle out_valid=1, out_wbdata=0x0000_00AA, out_regwrite=1.
REQ-037 out_ready=0, send beats A,B -> state TWO, in_ready=0, stall_cnt increments; raise out_ready -> A then B on consecutive cycles, in_ready=1 after A pops.
REQ-038 Beat with rd=0, regwrite=1 -> out_regwrite=0; memtoreg=1, memdata=0x1234_5678 -> out_wbdata=0x1234_5678.
REQ-039 flush in TWO concurrent with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered beat never appears.
REQ-040 CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; rst -> 0.
REQ-041 Random valid/ready traffic 10000 beats vs. scoreboard -> order preserved, no loss or duplication.
